stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Timekeeping controller for the stopwatch display path. It turns 1 Hz and 2 Hz tick strobes plus raw button and switch inputs into the `min`/`sec` values and `adjust`/`selection` controls consumed by the seven-segment display driver. It owns the run, pause and adjust sequencing and the base-60 counting. The display driver only renders these values.

## Interface
- `DB_CYCLES`, default 500000: consecutive stable cycles required to accept a button level (5 ms at 100 MHz).
- `MAX_VAL`, default 59: top value of both the minute and second fields.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick_1hz`  in  1  one-cycle strobe from the clock divider; drives run-mode counting.
- `tick_2hz`  in  1  one-cycle strobe; drives adjust-mode increments.
- `btn_pause`  in  1  raw, asynchronous pushbutton; toggles pause.
- `btn_clear`  in  1  raw, asynchronous pushbutton; clears the count to 00:00.
- `sw_adj`  in  1  raw slide switch; 1 = adjust mode.
- `sw_sel`  in  1  raw slide switch; 1 = seconds field selected, 0 = minutes field selected.
- `min`  out  6  minutes, 0..MAX_VAL, registered.
- `sec`  out  6  seconds, 0..MAX_VAL, registered.
- `adjust`  out  1  1 while in ADJ state, registered.
- `selection`  out  1  synchronized `sw_sel`, registered.
- `paused`  out  1  pause flag, registered.

## Operation
- **Reset values:** `min`=0, `sec`=0, `adjust`=0, `selection`=0, `paused`=0. State is RUN. Synchronizers and debouncers are cleared.
- **Input conditioning:**
  - Each raw input passes through a 2-flop synchronizer.
  - Each button is then debounced. The level is accepted only after DB_CYCLES consecutive identical samples.
  - An accepted 0->1 transition produces a one-cycle pulse (`pause_p`, `clear_p`).
- **States:**
  - RUN: counting.
  - PAUSE: holding.
  - ADJ: setting.
- **Transitions:**
  - Any state -> ADJ when synchronized `sw_adj`=1.
  - ADJ -> PAUSE when `sw_adj`=0 and `paused`=1; ADJ -> RUN when `sw_adj`=0 and `paused`=0.
  - RUN <-> PAUSE follows `paused`.
- **Pause:** `pause_p` toggles `paused` in every state. In ADJ the toggle is stored and takes effect on exit.
- **RUN counting:** on `tick_1hz`, `sec`+1.
  - At `sec`=MAX_VAL, `sec` goes to 0 and `min`+1.
  - At MAX_VAL:MAX_VAL the count wraps to 00:00.
- **ADJ counting:** on `tick_2hz`, the selected field +1, wrapping MAX_VAL -> 0. There is no carry into the other field. `tick_1hz` is ignored.
- **PAUSE:** both ticks are ignored.
- **Clear:** `clear_p` sets `min`=`sec`=0 in any state.
  - Clear wins over a tick in the same cycle.
  - `paused` and the state are unchanged.
- **Simultaneous events:** `pause_p` together with `tick_1hz` in RUN: the tick is still counted this cycle, and the pause takes effect from the next cycle.
- **Arithmetic:** 6-bit unsigned. Values above MAX_VAL are unreachable. If one is forced, the next increment loads 0.

## Timing
- Switch change -> `adjust`/`selection` change: 3 cycles (2 synchronizer + 1 output register).
- Button edge -> pulse: 2 + DB_CYCLES + 1 cycles after the raw edge, provided the level is stable throughout.
- Pulse or tick -> `min`/`sec`/`paused` update: visible on the next rising edge (1 cycle).
- Bounce shorter than DB_CYCLES produces no pulse. A held button produces exactly one pulse.
- When `rst_n` asserts mid-operation, outputs go to their reset values immediately (asynchronously). Counting resumes on the first tick after release.

## Structure
- **Package `stopwatch_pkg`:**
  - state enum {RUN, PAUSE, ADJ};
  - `TIME_W`=6;
  - `MAX_VAL_DEF`=59;
  - field-select encoding (`SEL_SEC`=1, `SEL_MIN`=0), shared with the display driver.
- **Sub-module `btn_debounce`:** 2-flop synchronizer, debounce counter and rising-edge pulse, parameterized by DB_CYCLES. Instantiated twice.
- **Top:** the switches use plain 2-flop synchronizers in the top level. The FSM and counters also live in the top level.

## Test plan
All scenarios use DB_CYCLES=4.

1. **Reset and wrap:** reset, then 61 `tick_1hz` strobes -> `min`=1, `sec`=1, `paused`=0. Preset 59:59, then one tick -> 00:00.
2. **Pause:** press `btn_pause` cleanly, then 5 ticks -> `paused`=1 and the count is unchanged. Press again, then 3 ticks -> `sec` advanced by 3.
3. **Adjust, seconds:** `sw_adj`=1, `sw_sel`=1, start 00:58, then 3 `tick_2hz` -> 00:01, `min` stays 0, `adjust`=1 after 3 cycles. `tick_1hz` has no effect.
4. **Adjust, minutes:** `sw_sel`=0, start 59:30, then 2 `tick_2hz` -> 01:30. Drop `sw_adj` -> RUN resumes.
5. **Debounce and clear:** bounce `btn_clear` with 3-cycle pulses -> no clear. Then a stable press at 12:34 coinciding with `tick_1hz` -> 00:00 and exactly one pulse.
6. **Async reset:** assert `rst_n`=0 mid-count at 05:07 in ADJ -> all outputs are 0 before the next clock edge, and the state is RUN after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, field widths and select codes for the stopwatch path.
package stopwatch_pkg;
    typedef enum logic [1:0] {RUN, PAUSE, ADJ} state_t;
    localparam int TIME_W = 6;
    localparam int MAX_VAL_DEF = 59;
    localparam logic SEL_SEC = 1'b1;
    localparam logic SEL_MIN = 1'b0;
    // Anything at or above the top value (including forced illegal values) reloads 0.
    function automatic logic [TIME_W-1:0] inc_wrap(input logic [TIME_W-1:0] v, input logic [TIME_W-1:0] top);
        return (v >= top) ? '0 : v + 1'b1;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a raw button, accepts a level after DB_CYCLES stable samples,
// and emits a one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic s1, s2, level, level_d;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            level <= 1'b0;
            level_d <= 1'b0;
            cnt <= '0;
            pulse <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            // Any sample agreeing with the accepted level restarts the stability count.
            if (s2 == level)
                cnt <= '0;
            else if (cnt == CW'(DB_CYCLES - 1)) begin
                cnt <= '0;
                level <= s2;
            end else
                cnt <= cnt + 1'b1;
            level_d <= level;
            pulse <= level & ~level_d;
        end
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust sequencing and base-60 counting feeding the display driver.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = 500000,
    parameter int MAX_VAL = MAX_VAL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1hz,
    input  logic              tick_2hz,
    input  logic              btn_pause,
    input  logic              btn_clear,
    input  logic              sw_adj,
    input  logic              sw_sel,
    output logic [TIME_W-1:0] min,
    output logic [TIME_W-1:0] sec,
    output logic              adjust,
    output logic              selection,
    output logic              paused
);
    localparam logic [TIME_W-1:0] TOP = TIME_W'(MAX_VAL);
    logic pause_p, clear_p, paused_next;
    logic [1:0] adj_sync, sel_sync;
    state_t state;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_pause (.clk(clk), .rst_n(rst_n), .btn(btn_pause), .pulse(pause_p));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clear (.clk(clk), .rst_n(rst_n), .btn(btn_clear), .pulse(clear_p));

    // A toggle taken while adjusting is held in paused and applied when ADJ is left.
    assign paused_next = paused ^ pause_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adj_sync <= '0;
            sel_sync <= '0;
            adjust <= 1'b0;
            selection <= 1'b0;
            paused <= 1'b0;
            state <= RUN;
            min <= '0;
            sec <= '0;
        end else begin
            adj_sync <= {adj_sync[0], sw_adj};
            sel_sync <= {sel_sync[0], sw_sel};
            adjust <= adj_sync[1];
            selection <= sel_sync[1];
            paused <= paused_next;
            state <= adj_sync[1] ? ADJ : (paused_next ? PAUSE : RUN);
            if (clear_p) begin
                min <= '0;
                sec <= '0;
            end else if (state == ADJ && tick_2hz) begin
                if (selection == SEL_SEC)
                    sec <= inc_wrap(sec, TOP);
                else
                    min <= inc_wrap(min, TOP);
            end else if (state == RUN && tick_1hz) begin
                sec <= inc_wrap(sec, TOP);
                if (sec >= TOP)
                    min <= inc_wrap(min, TOP);
            end
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenarios checked each cycle against a time-level model of the stopwatch.
module tb_stopwatch_ctrl;
    localparam int DB = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick_1hz = 1'b0, tick_2hz = 1'b0, btn_pause = 1'b0, btn_clear = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
    logic [5:0] d_min, d_sec;
    logic d_adj, d_sel, d_paused;
    int vectors = 0;
    int errors = 0;

    logic [5:0] m_min, m_sec;
    logic m_adj, m_sel, m_paused;
    logic [DB+1:0] hp, hc, ha, hs;
    logic lp, lc;
    logic [1:0] pp, cp;
    logic acc_p, acc_c;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DB_CYCLES(DB), .MAX_VAL(59)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .btn_pause(btn_pause), .btn_clear(btn_clear), .sw_adj(sw_adj), .sw_sel(sw_sel),
        .min(d_min), .sec(d_sec), .adjust(d_adj), .selection(d_sel), .paused(d_paused)
    );

    // A press is accepted once DB consecutive synchronized samples disagree with the held level;
    // its effect lands two edges after acceptance.
    assign acc_p = lp ? (hp[DB:1] == '0) : (&hp[DB:1]);
    assign acc_c = lc ? (hc[DB:1] == '0) : (&hc[DB:1]);

    function automatic int next_t();
        int t = m_min * 60 + m_sec;
        if (cp[1]) return 0;
        if (m_adj && tick_2hz) return m_sel ? m_min * 60 + (m_sec + 1) % 60 : ((m_min + 1) % 60) * 60 + m_sec;
        if (!m_adj && !m_paused && tick_1hz) return (t + 1) % 3600;
        return t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_min <= '0; m_sec <= '0; m_adj <= 1'b0; m_sel <= 1'b0; m_paused <= 1'b0;
            hp <= '0; hc <= '0; ha <= '0; hs <= '0;
            lp <= 1'b0; lc <= 1'b0; pp <= '0; cp <= '0;
        end else begin
            m_min <= 6'(next_t() / 60);
            m_sec <= 6'(next_t() % 60);
            m_paused <= m_paused ^ pp[1];
            hp <= {hp[DB:0], btn_pause};
            hc <= {hc[DB:0], btn_clear};
            ha <= {ha[DB:0], sw_adj};
            hs <= {hs[DB:0], sw_sel};
            if (acc_p) lp <= ~lp;
            if (acc_c) lc <= ~lc;
            pp <= {pp[0], acc_p & ~lp};
            cp <= {cp[0], acc_c & ~lc};
            m_adj <= ha[1];
            m_sel <= hs[1];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("min", d_min, m_min);
        check("sec", d_sec, m_sec);
        check("adjust", d_adj, m_adj);
        check("selection", d_sel, m_sel);
        check("paused", d_paused, m_paused);
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick1(input int n = 1);
        repeat (n) begin tick_1hz = 1'b1; step(); tick_1hz = 1'b0; end
    endtask

    task automatic tick2(input int n = 1);
        repeat (n) begin tick_2hz = 1'b1; step(); tick_2hz = 1'b0; end
    endtask

    task automatic time_is(input string name, input int mm, input int ss);
        check({name, ".min"}, d_min, mm);
        check({name, ".sec"}, d_sec, ss);
    endtask

    task automatic press_pause();
        btn_pause = 1'b1; step(DB + 6);
        btn_pause = 1'b0; step(DB + 4);
    endtask

    initial begin
        step(3);
        rst_n = 1'b1;
        time_is("reset", 0, 0);
        check("reset.adjust", d_adj, 0);
        check("reset.selection", d_sel, 0);
        check("reset.paused", d_paused, 0);
        tick1(61);
        time_is("run61", 1, 1);
        check("run61.paused", d_paused, 0);
        sw_adj = 1'b1; sw_sel = 1'b0; step(4);
        tick2(58);
        sw_sel = 1'b1; step(4);
        tick2(58);
        time_is("preset", 59, 59);
        sw_adj = 1'b0; step(4);
        tick1();
        time_is("wrap", 0, 0);

        press_pause();
        check("pause.on", d_paused, 1);
        tick1(5);
        time_is("paused", 0, 0);
        press_pause();
        tick1(3);
        time_is("resumed", 0, 3);
        check("pause.off", d_paused, 0);

        sw_adj = 1'b1; sw_sel = 1'b1; step(2);
        check("adj.lat2", d_adj, 0);
        step();
        check("adj.lat3", d_adj, 1);
        tick2(55);
        time_is("adj58", 0, 58);
        tick2(3);
        time_is("adjsec", 0, 1);
        tick1(3);
        time_is("adj1hz", 0, 1);

        tick2(29);
        sw_sel = 1'b0; step(4);
        check("sel.min", d_sel, 0);
        tick2(59);
        time_is("adj5930", 59, 30);
        tick2(2);
        time_is("adjmin", 1, 30);
        sw_adj = 1'b0; step(4);
        check("adj.off", d_adj, 0);
        tick1();
        time_is("runagain", 1, 31);

        repeat (3) begin btn_clear = 1'b1; step(3); btn_clear = 1'b0; step(2); end
        step(DB + 6);
        time_is("bounce", 1, 31);
        sw_adj = 1'b1; sw_sel = 1'b0; step(4);
        tick2(11);
        sw_sel = 1'b1; step(4);
        tick2(3);
        sw_adj = 1'b0; step(4);
        time_is("preset1234", 12, 34);
        btn_clear = 1'b1; step(DB + 3);
        tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
        time_is("clear", 0, 0);
        step(10);
        tick1();
        time_is("held", 0, 1);
        btn_clear = 1'b0; step(DB + 6);
        tick1();
        time_is("released", 0, 2);

        sw_adj = 1'b1; sw_sel = 1'b0; step(4);
        tick2(5);
        sw_sel = 1'b1; step(4);
        tick2(5);
        time_is("pre_rst", 5, 7);
        check("pre_rst.adjust", d_adj, 1);
        #2 rst_n = 1'b0;
        #1;
        time_is("async_rst", 0, 0);
        check("async_rst.adjust", d_adj, 0);
        check("async_rst.selection", d_sel, 0);
        check("async_rst.paused", d_paused, 0);
        sw_adj = 1'b0; sw_sel = 1'b0; step(3);
        rst_n = 1'b1; step(4);
        check("post_rst.adjust", d_adj, 0);
        tick1();
        time_is("post_rst", 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
